// File: rtl/mux_channel_scanner.sv
// mux_channel_scanner: steps the select lines of a 4:1 mux through channels
// 0..3, holds each for DWELL cycles, samples the mux output, and hands the
// packed 4-bit frame downstream on a valid/ready handshake.
// Optional feature macro: FRAME_PARITY_EN adds a registered frame_parity output.
module mux_channel_scanner #(
    parameter int DWELL = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       continuous,
    input  logic       mux_out,
    output logic [1:0] sel,
    output logic       busy,
    output logic [3:0] frame_data,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       overrun
`ifdef FRAME_PARITY_EN
    ,
    output logic       frame_parity
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [7:0] LAST = 8'(DWELL - 1);

    state_t     state, state_next;
    logic [7:0] cnt;
    logic [2:0] shadow;
    logic       launch;
    logic       sample;
    logic       handshake;

    // Registered FSM state.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state decode plus the per-cycle event strobes used by the datapath.
    always_comb begin
        state_next = state;
        launch     = 1'b0;
        sample     = 1'b0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                if (start | continuous) begin
                    launch     = 1'b1;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == LAST) begin
                    sample = 1'b1;
                    if (sel == 2'd3) state_next = HOLD;
                end
            end
            HOLD: begin
                if (frame_ready) begin
                    handshake  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Dwell counter and select stepping; sel never wraps mid-scan, channel 3
    // goes straight to HOLD and sel returns to 0 only once the frame is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel <= 2'd0;
            cnt <= 8'd0;
        end else if (launch) begin
            sel <= 2'd0;
            cnt <= 8'd0;
        end else if (sample) begin
            cnt <= 8'd0;
            if (sel != 2'd3) sel <= sel + 2'd1;
        end else if (state == SETTLE) begin
            cnt <= cnt + 8'd1;
        end else if (handshake) begin
            sel <= 2'd0;
        end
    end

    // Sample capture: channels 0..2 go to the shadow, channel 3 goes straight
    // into the frame together with the shadow so the frame updates atomically.
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow      <= 3'd0;
            frame_data  <= 4'd0;
            frame_valid <= 1'b0;
        end else begin
            if (sample && sel != 2'd3) shadow[sel] <= mux_out;
            if (sample && sel == 2'd3) begin
                frame_data  <= {mux_out, shadow};
                frame_valid <= 1'b1;
            end else if (handshake) begin
                frame_valid <= 1'b0;
            end
        end
    end

`ifdef FRAME_PARITY_EN
    // Parity registered alongside the frame it covers.
    always_ff @(posedge clk) begin
        if (rst)                       frame_parity <= 1'b0;
        else if (sample && sel == 2'd3) frame_parity <= ^{mux_out, shadow};
    end
`endif

    // Sticky flag for a start request arriving while a scan is in flight.
    always_ff @(posedge clk) begin
        if (rst)                        overrun <= 1'b0;
        else if (start && state != IDLE) overrun <= 1'b1;
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mux_channel_scanner.sv
// Scoreboarded bench for mux_channel_scanner (DWELL=2). Expected frames are
// queued when a scan is launched; a negedge monitor pops one per handshake.
module tb_mux_channel_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       continuous;
    logic       mux_out;
    logic [1:0] sel;
    logic       busy;
    logic [3:0] frame_data;
    logic       frame_valid;
    logic       frame_ready;
    logic       overrun;
`ifdef FRAME_PARITY_EN
    logic       frame_parity;
`endif

    logic [3:0] chans;
    logic [3:0] exp_q[$];
    int         n_chk  = 0;
    int         n_pass = 0;

    always #5 clk = ~clk;

    // Behavioural 4:1 mux: channel k presented when sel==k.
    assign mux_out = chans[sel];

    mux_channel_scanner #(.DWELL(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .continuous  (continuous),
        .mux_out     (mux_out),
        .sel         (sel),
        .busy        (busy),
        .frame_data  (frame_data),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .overrun     (overrun)
`ifdef FRAME_PARITY_EN
        ,
        .frame_parity(frame_parity)
`endif
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard monitor: every completed handshake must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && frame_valid && frame_ready) begin
            if (exp_q.size() == 0) chk("frame_unexpected", 32'(frame_data), 32'hFFFF);
            else chk("frame_data", 32'(frame_data), 32'(exp_q.pop_front()));
        end
    end

    initial begin
        int nfr;
        int last;
        rst = 1'b1; start = 1'b0; continuous = 1'b0; frame_ready = 1'b0; chans = 4'b0000;
        cyc(3);
        chk("rst_sel", 32'(sel), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_valid", 32'(frame_valid), 0);
        chk("rst_data", 32'(frame_data), 0);
        chk("rst_overrun", 32'(overrun), 0);
        rst = 1'b0;
        cyc(1);

        // Reset mid-scan: everything cleared, partial scan never produces a frame.
        chans = 4'b1111;
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(4);
        rst = 1'b1;
        cyc(1);
        chk("midrst_sel", 32'(sel), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_valid", 32'(frame_valid), 0);
        chk("midrst_data", 32'(frame_data), 0);
        cyc(2);
        rst = 1'b0;
        nfr = 0;
        for (int i = 0; i < 12; i++) begin
            cyc(1);
            if (frame_valid || busy) nfr++;
        end
        chk("midrst_no_frame", 32'(nfr), 0);

        // Single scan, channel pattern a=1 b=0 c=1 d=1.
        chans = 4'b1101;
        exp_q.push_back(4'b1101);
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        chk("scan_busy", 32'(busy), 1);
        chk("scan_sel_t1", 32'(sel), 0);
        for (int k = 2; k <= 8; k++) begin
            cyc(1);
            chk("scan_sel", 32'(sel), 32'((k - 1) / 2));
            chk("scan_not_valid", 32'(frame_valid), 0);
        end
        cyc(1);
        chk("scan_valid_t9", 32'(frame_valid), 1);
        chk("scan_data_t9", 32'(frame_data), 32'h0D);
`ifdef FRAME_PARITY_EN
        chk("parity_1101", 32'(frame_parity), 1);
`endif
        // Back-pressure in HOLD.
        for (int i = 0; i < 5; i++) begin
            cyc(1);
            chk("hold_valid", 32'(frame_valid), 1);
            chk("hold_data", 32'(frame_data), 32'h0D);
            chk("hold_sel", 32'(sel), 3);
        end
        frame_ready = 1'b1;
        cyc(1);
        frame_ready = 1'b0;
        chk("post_hs_valid", 32'(frame_valid), 0);
        chk("post_hs_busy", 32'(busy), 0);
        chk("post_hs_sel", 32'(sel), 0);
        chk("post_hs_data", 32'(frame_data), 32'h0D);

        // Continuous scanning with ready tied high.
        chans = 4'b0110;
        repeat (3) exp_q.push_back(4'b0110);
        frame_ready = 1'b1;
        continuous = 1'b1;
        nfr = 0;
        last = 0;
        for (int i = 1; i <= 40 && nfr < 3; i++) begin
            cyc(1);
            if (frame_valid) begin
                nfr++;
                if (nfr == 1) chk("cont_first", 32'(i), 9);
                else chk("cont_period", 32'(i - last), 10);
                last = i;
                if (nfr == 3) continuous = 1'b0;
            end
        end
        chk("cont_frames", 32'(nfr), 3);
        cyc(1);
        chk("cont_end_sel", 32'(sel), 0);
        chk("cont_end_busy", 32'(busy), 0);
        chk("cont_no_overrun", 32'(overrun), 0);
        cyc(2);
        chk("cont_idle", 32'(busy), 0);
        frame_ready = 1'b0;

        // Start pulsed during SETTLE: dropped, sticky overrun, scan unaffected.
        chans = 4'b1001;
        exp_q.push_back(4'b1001);
        start = 1'b1;
        cyc(1);
        chk("ovr_before", 32'(overrun), 0);
        cyc(1);
        start = 1'b0;
        chk("ovr_set", 32'(overrun), 1);
        cyc(7);
        chk("ovr_valid_t9", 32'(frame_valid), 1);
        chk("ovr_data", 32'(frame_data), 32'h09);
`ifdef FRAME_PARITY_EN
        chk("parity_1001", 32'(frame_parity), 0);
`endif
        frame_ready = 1'b1;
        cyc(1);
        frame_ready = 1'b0;
        chk("ovr_post_valid", 32'(frame_valid), 0);
        cyc(3);
        chk("ovr_sticky", 32'(overrun), 1);
        chk("queue_empty", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
